// File: rtl/cube_pkg.sv
// cube_pkg: shared definitions for the cube-root unit.
//   cube_state_e  - controller states (IDLE, SHIFT, MUL, CMP)
//   S_INIT/S_STEP - initial shift amount and per-step decrement
//   MUL_CYCLES    - cycles from multiplier launch to result
//   cmp_value     - trial subtrahend (3t+1) << s
package cube_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        CMP   = 2'd3
    } cube_state_e;

    localparam logic [2:0] S_INIT     = 3'd6;
    localparam logic [2:0] S_STEP     = 3'd3;
    localparam int         MUL_CYCLES = 8;

    // Trial value for one digit step; t = y*(y+1) already doubled-y based.
    function automatic logic [15:0] cmp_value(input logic [15:0] t, input logic [2:0] s);
        logic [15:0] tri_s;
        tri_s = (t << 1) + t + 16'd1;
        return tri_s << s;
    endfunction

endpackage

// File: rtl/cube_mult.sv
// mult: sequential 8x8 -> 16 shift-add multiplier.
//   clk_i    clock
//   rst_i    asynchronous active-low reset
//   start_i  launch request, accepted when idle (operands sampled then)
//   a_bi     multiplicand
//   b_bi     multiplier
//   busy_o   high while partial products are still being accumulated
//   y_bo     product, valid once busy_o is low after a launch
// The launch edge already folds in bit 0, so the result is ready
// MUL_CYCLES cycles after the cycle in which start_i was presented.
module mult
    import cube_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  a_bi,
    input  logic [7:0]  b_bi,
    output logic        busy_o,
    output logic [15:0] y_bo
);

    localparam logic [2:0] LAST_CNT = 3'(MUL_CYCLES - 2);

    logic [15:0] mcand_r;
    logic [7:0]  mplier_r;
    logic [15:0] acc_r;
    logic [2:0]  cnt_r;
    logic        busy_r;

    // Shift-add datapath: one multiplier bit per clock.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_r  <= 16'd0;
            mplier_r <= 8'd0;
            acc_r    <= 16'd0;
            cnt_r    <= 3'd0;
            busy_r   <= 1'b0;
        end else if (busy_r) begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : 16'd0);
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + 3'd1;
            busy_r   <= (cnt_r != LAST_CNT);
        end else if (start_i) begin
            acc_r    <= b_bi[0] ? {8'd0, a_bi} : 16'd0;
            mcand_r  <= {8'd0, a_bi} << 1;
            mplier_r <= b_bi >> 1;
            cnt_r    <= 3'd0;
            busy_r   <= 1'b1;
        end else begin
            busy_r   <= 1'b0;
        end
    end

    assign busy_o = busy_r;
    assign y_bo   = acc_r;

endmodule

// File: rtl/cube.sv
// cube: sequential floor(cbrt(x)) for an 8-bit unsigned operand.
//   clk_i    clock
//   rst_i    asynchronous active-low reset; aborts any computation
//   start_i  level start request, sampled only while idle
//   x_bi     operand, captured on the accepting edge
//   busy_o   high for exactly 31 cycles per computation
//   y_bo     result register, updated on the edge busy_o falls
// Digit-by-digit root over shifts 6, 3, 0; each step is SHIFT (1),
// MUL (8), CMP (1). The first SHIFT after acceptance spends one extra
// cycle settling the captured operand, giving the fixed 31-cycle latency.
module cube
    import cube_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] x_bi,
    output logic       busy_o,
    output logic [7:0] y_bo
);

    cube_state_e state_r;
    logic [7:0]  xr_r;
    logic [7:0]  y_r;
    logic [2:0]  s_r;
    logic [15:0] t_r;
    logic        prime_r;
    logic        busy_r;
    logic [7:0]  y_out_r;

    logic [7:0]  mul_a_s;
    logic [7:0]  mul_b_s;
    logic        mul_start_s;
    logic        mul_busy_s;
    logic [15:0] mul_y_s;
    logic [15:0] b_s;
    logic        ge_s;
    logic [7:0]  y_next_s;

    // Multiplier operands y2*(y2+1) with y2 the doubled partial root.
    always_comb begin
        mul_a_s     = y_r << 1;
        mul_b_s     = mul_a_s + 8'd1;
        mul_start_s = (state_r == SHIFT) && !prime_r;
    end

    // Trial compare and root update for the CMP cycle.
    always_comb begin
        b_s      = cmp_value(t_r, s_r);
        ge_s     = ({8'd0, xr_r} >= b_s);
        y_next_s = ge_s ? (y_r + 8'd1) : y_r;
    end

    mult u_mult (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start_s),
        .a_bi    (mul_a_s),
        .b_bi    (mul_b_s),
        .busy_o  (mul_busy_s),
        .y_bo    (mul_y_s)
    );

    // Controller FSM with working registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            xr_r    <= 8'd0;
            y_r     <= 8'd0;
            s_r     <= 3'd0;
            t_r     <= 16'd0;
            prime_r <= 1'b0;
            busy_r  <= 1'b0;
            y_out_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        xr_r    <= x_bi;
                        y_r     <= 8'd0;
                        s_r     <= S_INIT;
                        prime_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (prime_r) begin
                        prime_r <= 1'b0;
                    end else begin
                        y_r     <= y_r << 1;
                        state_r <= MUL;
                    end
                end
                MUL: begin
                    if (!mul_busy_s) begin
                        t_r     <= mul_y_s;
                        state_r <= CMP;
                    end else begin
                        t_r     <= t_r;
                    end
                end
                CMP: begin
                    if (ge_s) begin
                        xr_r <= xr_r - b_s[7:0];
                    end else begin
                        xr_r <= xr_r;
                    end
                    y_r <= y_next_s;
                    if (s_r == 3'd0) begin
                        y_out_r <= y_next_s;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        s_r     <= s_r - S_STEP;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_r;
    assign y_bo   = y_out_r;

endmodule

// File: tb/tb_cube.sv
// tb_cube: randomized self-checking bench for cube against a
// floor(cbrt) reference computed by plain integer search.
module tb_cube;

    logic       clk_i   = 1'b0;
    logic       rst_i   = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] x_bi    = 8'd0;
    logic       busy_o;
    logic [7:0] y_bo;

    int         tests  = 0;
    int         errors = 0;
    logic [7:0] last_y = 8'd0;

    cube dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .x_bi    (x_bi),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] ref_cbrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return 8'(r);
    endfunction

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One computation; noisy runs scramble x_bi and start_i while busy.
    task automatic run_op(input logic [7:0] x, input bit noisy);
        int hi;
        @(negedge clk_i);
        start_i = 1'b1;
        x_bi    = x;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        hi = 0;
        while (busy_o === 1'b1 && hi < 100) begin
            if (hi == 3) check_val("y_hold", 16'(y_bo), 16'(last_y));
            if (noisy) begin
                x_bi    = 8'($urandom);
                start_i = (hi < 25) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(posedge clk_i); #1;
            hi++;
        end
        start_i = 1'b0;
        check_val("busy_len", 16'(hi), 16'd31);
        check_val("result", 16'(y_bo), 16'(ref_cbrt(int'(x))));
        last_y = ref_cbrt(int'(x));
    endtask

    initial begin
        logic [7:0] dir_x [10] = '{8'd0, 8'd1, 8'd8, 8'd27, 8'd64,
                                   8'd7, 8'd26, 8'd63, 8'd124, 8'd255};
        int n;
        int hi;
        int lo;

        #12;
        check_val("rst_busy", 16'(busy_o), 16'd0);
        check_val("rst_y", 16'(y_bo), 16'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (dir_x[i]) run_op(dir_x[i], 1'b0);

        for (int i = 0; i < 40; i++) run_op(8'($urandom), 1'b1);

        for (int i = 0; i < 256; i++) run_op(8'(i), 1'b0);

        // Reset in the middle of a run with a nonzero prior result.
        @(negedge clk_i);
        start_i = 1'b1;
        x_bi    = 8'd216;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (14) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check_val("midrst_busy", 16'(busy_o), 16'd0);
        check_val("midrst_y", 16'(y_bo), 16'd0);
        last_y = 8'd0;
        @(negedge clk_i);
        rst_i = 1'b1;
        run_op(8'd216, 1'b0);

        // Start held high: back-to-back runs with a one-cycle gap.
        @(negedge clk_i);
        start_i = 1'b1;
        x_bi    = 8'd125;
        @(posedge clk_i); #1;
        for (int r = 0; r < 3; r++) begin
            hi = 0;
            while (busy_o === 1'b1 && hi < 100) begin
                @(posedge clk_i); #1;
                hi++;
            end
            check_val("held_hi", 16'(hi), 16'd31);
            check_val("held_y", 16'(y_bo), 16'd5);
            lo = 0;
            while (busy_o !== 1'b1 && lo < 10) begin
                @(posedge clk_i); #1;
                lo++;
            end
            check_val("held_lo", 16'(lo), 16'd1);
        end
        start_i = 1'b0;
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_val("held_drain", 16'(y_bo), 16'd5);

        // Operand change and start pulse while busy must not disturb the run.
        @(negedge clk_i);
        start_i = 1'b1;
        x_bi    = 8'd27;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        x_bi    = 8'd200;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n = 4;
        while (busy_o === 1'b1 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_val("chg_len", 16'(n), 16'd31);
        check_val("chg_y", 16'(y_bo), 16'd3);
        @(posedge clk_i); #1;
        check_val("chg_norestart", 16'(busy_o), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
